// File: rtl/aq_sdram_scheduler.sv
// Acquisition scheduler: antenna samples -> circular FIFO -> MCB writes.
// Arm/capture/drain/done cycle with sticky overflow and debug state.
module aq_sdram_scheduler #(
  parameter int AXNUM = 24,
  parameter int MSB   = AXNUM - 1,
  parameter int ABITS = 20,
  parameter int ASB   = ABITS - 2,
  parameter int BBITS = 9,
  parameter int DELAY = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         aq_ce_i,
  input  logic         aq_valid_i,
  input  logic [MSB:0] aq_data_i,
  input  logic         rd_req_i,
  output logic         mcb_ce_o,
  output logic         mcb_wr_o,
  input  logic         mcb_rdy_i,
  output logic [ASB:0] mcb_adr_o,
  output logic [31:0]  mcb_dat_o,
  output logic         overflow_o,
  output logic [2:0]   tart_state
);

  // DELAY is kept for parameter compatibility with the original
  // simulation model; the RTL itself has no timing delays.
  localparam int DEPTH = 1 << BBITS;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_DRAIN   = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;

  localparam logic [ABITS-1:0] L_LAST = {1'b0, {(ABITS-1){1'b1}}};
  localparam logic [BBITS:0]   L_ONE  = {{BBITS{1'b0}}, 1'b1};

  logic [MSB:0]       r_mem [DEPTH];
  logic [BBITS-1:0]   r_wp;
  logic [BBITS-1:0]   r_rp;
  logic [BBITS:0]     r_cnt;
  logic [ABITS-1:0]   r_scnt;
  logic [ASB:0]       r_adr;
  logic [2:0]         r_state;
  logic [2:0]         w_next;

  logic               w_xfer;
  logic               w_take;
  logic               w_push;
  logic               w_drop;
  logic               w_last;
  logic               w_start;
  logic               w_has_next;
  logic               w_load;
  logic [BBITS-1:0]   w_rd_ptr;

  // The FIFO head stays counted until its MCB command transfers,
  // so the command register never holds more than the FIFO depth.
  assign w_xfer     = mcb_ce_o & mcb_rdy_i;
  assign w_take     = (r_state == ST_CAPTURE) & aq_ce_i & aq_valid_i;
  assign w_push     = w_take & (~r_cnt[BBITS] | w_xfer);
  assign w_drop     = w_take & ~w_push;
  assign w_last     = w_push & (r_scnt == L_LAST);
  assign w_start    = (r_state == ST_IDLE) & aq_ce_i;
  assign w_has_next = w_xfer ? (r_cnt > L_ONE) : (r_cnt != '0);
  assign w_load     = (~mcb_ce_o | mcb_rdy_i) & w_has_next;
  assign w_rd_ptr   = w_xfer ? r_rp + 1'b1 : r_rp;

  // Next-state selection for the arm/capture/drain/done cycle
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:    w_next = aq_ce_i ? ST_CAPTURE : ST_IDLE;
      ST_CAPTURE: w_next = (!aq_ce_i || w_last) ? ST_DRAIN : ST_CAPTURE;
      ST_DRAIN:   w_next = (r_cnt == '0 && !mcb_ce_o) ? ST_DONE : ST_DRAIN;
      ST_DONE:    w_next = rd_req_i ? ST_IDLE : ST_DONE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Sample storage; contents need no reset because pointers are cleared
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= aq_data_i;
  end

  // State, FIFO bookkeeping, sample counter and overflow flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_scnt     <= '0;
      overflow_o <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_xfer) r_rp <= r_rp + 1'b1;
      case ({w_push, w_xfer})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_start) begin
        r_scnt     <= '0;
        overflow_o <= 1'b0;
      end else begin
        if (w_push) r_scnt <= r_scnt + 1'b1;
        if (w_drop) overflow_o <= 1'b1;
      end
    end
  end

  // MCB command register: holds while stalled, reloads back-to-back
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcb_ce_o  <= 1'b0;
      mcb_wr_o  <= 1'b0;
      mcb_adr_o <= '0;
      mcb_dat_o <= '0;
      r_adr     <= '0;
    end else begin
      if (!mcb_ce_o || mcb_rdy_i) begin
        mcb_ce_o <= w_has_next;
        mcb_wr_o <= w_has_next;
      end
      if (w_load) begin
        mcb_adr_o <= r_adr;
        mcb_dat_o <= 32'(r_mem[w_rd_ptr]);
      end
      if (w_start) r_adr <= '0;
      else if (w_load) r_adr <= r_adr + 1'b1;
    end
  end

  assign tart_state = r_state;

endmodule

// File: tb/tb_aq_sdram_scheduler.sv
// Scoreboard bench for aq_sdram_scheduler (ABITS=6, BBITS=2).
// Stimulus queues expected MCB writes; a monitor checks each transfer.
module tb_aq_sdram_scheduler;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        aq_ce_i;
  logic        aq_valid_i;
  logic [23:0] aq_data_i;
  logic        rd_req_i;
  logic        mcb_ce_o;
  logic        mcb_wr_o;
  logic        mcb_rdy_i;
  logic [4:0]  mcb_adr_o;
  logic [31:0] mcb_dat_o;
  logic        overflow_o;
  logic [2:0]  tart_state;

  int checks = 0;
  int errors = 0;
  int n_xfer = 0;
  logic [31:0] q_adr[$];
  logic [31:0] q_dat[$];

  always #5 clk = ~clk;

  aq_sdram_scheduler #(
    .AXNUM(24), .ABITS(6), .BBITS(2)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .aq_ce_i(aq_ce_i), .aq_valid_i(aq_valid_i),
    .aq_data_i(aq_data_i), .rd_req_i(rd_req_i),
    .mcb_ce_o(mcb_ce_o), .mcb_wr_o(mcb_wr_o),
    .mcb_rdy_i(mcb_rdy_i), .mcb_adr_o(mcb_adr_o),
    .mcb_dat_o(mcb_dat_o), .overflow_o(overflow_o),
    .tart_state(tart_state)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted MCB command is matched against the queue
  always @(negedge clk) begin
    if (!rst_i && mcb_ce_o && mcb_rdy_i) begin
      n_xfer++;
      if (q_adr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected got adr %0h dat %0h want none",
                 mcb_adr_o, mcb_dat_o);
      end else begin
        chk("xfer_adr", 32'(mcb_adr_o), q_adr.pop_front());
        chk("xfer_dat", mcb_dat_o, q_dat.pop_front());
        chk("xfer_wr", 32'(mcb_wr_o), 32'd1);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int a, input logic [23:0] d);
    q_adr.push_back(32'(a));
    q_dat.push_back({8'h00, d});
  endtask

  task automatic wait_done(input bit tog, input int maxc);
    int n = 0;
    while (tart_state !== 3'd3 && n < maxc) begin
      if (tog) mcb_rdy_i = ~mcb_rdy_i;
      cyc();
      n++;
    end
    chk("reach_done", 32'(tart_state), 32'd3);
  endtask

  task automatic rearm_check();
    rd_req_i = 1'b1;
    cyc();
    rd_req_i = 1'b0;
    chk("rd_req_idle", 32'(tart_state), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; aq_ce_i = 1'b0; aq_valid_i = 1'b1;
    aq_data_i = 24'h0; rd_req_i = 1'b0; mcb_rdy_i = 1'b0;

    // 1: reset and idle with stray valid
    cyc(); cyc();
    rst_i = 1'b0;
    cyc(); cyc();
    chk("rst_ce", 32'(mcb_ce_o), 32'd0);
    chk("rst_wr", 32'(mcb_wr_o), 32'd0);
    chk("rst_adr", 32'(mcb_adr_o), 32'd0);
    chk("rst_dat", mcb_dat_o, 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_state", 32'(tart_state), 32'd0);

    // 2: full 32-word capture at full rate
    aq_valid_i = 1'b0; mcb_rdy_i = 1'b1; aq_ce_i = 1'b1;
    n_xfer = 0;
    cyc();
    chk("cap_state", 32'(tart_state), 32'd1);
    for (int i = 1; i <= 32; i++) begin
      aq_valid_i = 1'b1;
      aq_data_i = 24'(i);
      expect_wr(i - 1, 24'(i));
      cyc();
    end
    aq_valid_i = 1'b0;
    chk("full_drain", 32'(tart_state), 32'd2);
    aq_ce_i = 1'b0;
    wait_done(1'b0, 20);
    chk("full_nxfer", 32'(n_xfer), 32'd32);
    chk("full_ovf", 32'(overflow_o), 32'd0);
    chk("full_qempty", 32'(q_adr.size()), 32'd0);
    rearm_check();

    // 3: backpressure, only four samples fit
    n_xfer = 0; mcb_rdy_i = 1'b0; aq_ce_i = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      aq_valid_i = 1'b1;
      aq_data_i = 24'hA1 + 24'(i);
      if (i < 4) expect_wr(i, 24'hA1 + 24'(i));
      cyc();
    end
    aq_valid_i = 1'b0;
    rd_req_i = 1'b1;
    cyc();
    rd_req_i = 1'b0;
    chk("rdreq_ignored", 32'(tart_state), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_adr", 32'(mcb_adr_o), 32'd0);
      chk("stall_dat", mcb_dat_o, 32'hA1);
      chk("stall_ce", 32'(mcb_ce_o), 32'd1);
    end
    chk("bp_ovf", 32'(overflow_o), 32'd1);
    mcb_rdy_i = 1'b1; aq_ce_i = 1'b0;
    wait_done(1'b0, 20);
    chk("bp_nxfer", 32'(n_xfer), 32'd4);
    rearm_check();

    // 4: push into a full FIFO on a pop cycle
    n_xfer = 0; mcb_rdy_i = 1'b0; aq_ce_i = 1'b1;
    cyc();
    chk("rearm_ovf_clr", 32'(overflow_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      aq_valid_i = 1'b1;
      aq_data_i = 24'hC1 + 24'(i);
      expect_wr(i, 24'hC1 + 24'(i));
      cyc();
    end
    mcb_rdy_i = 1'b1;
    aq_data_i = 24'hC5;
    expect_wr(4, 24'hC5);
    cyc();
    chk("fullpop_ovf", 32'(overflow_o), 32'd0);
    mcb_rdy_i = 1'b0;
    aq_data_i = 24'hC6;
    cyc();
    chk("still_full_ovf", 32'(overflow_o), 32'd1);
    aq_valid_i = 1'b0; mcb_rdy_i = 1'b1; aq_ce_i = 1'b0;
    wait_done(1'b0, 20);
    chk("fullpop_nxfer", 32'(n_xfer), 32'd5);
    rearm_check();

    // 5: early stop with toggling ready, then re-arm
    n_xfer = 0; mcb_rdy_i = 1'b0; aq_ce_i = 1'b1;
    cyc();
    chk("es_ovf_clr", 32'(overflow_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      mcb_rdy_i = (i % 2 == 0);
      aq_valid_i = 1'b1;
      aq_data_i = 24'h5000 + 24'(i);
      expect_wr(i, 24'h5000 + 24'(i));
      cyc();
    end
    aq_valid_i = 1'b0; aq_ce_i = 1'b0;
    wait_done(1'b1, 30);
    chk("es_nxfer", 32'(n_xfer), 32'd5);
    chk("es_ovf", 32'(overflow_o), 32'd0);
    rearm_check();
    n_xfer = 0; mcb_rdy_i = 1'b1; aq_ce_i = 1'b1;
    cyc();
    aq_valid_i = 1'b1;
    aq_data_i = 24'h600001;
    expect_wr(0, 24'h600001);
    cyc();
    aq_valid_i = 1'b0; aq_ce_i = 1'b0;
    wait_done(1'b0, 20);
    chk("rearm_nxfer", 32'(n_xfer), 32'd1);
    rearm_check();

    // 6: reset while a command is pending
    n_xfer = 0; mcb_rdy_i = 1'b0; aq_ce_i = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      aq_valid_i = 1'b1;
      aq_data_i = 24'hE1 + 24'(i);
      cyc();
    end
    aq_valid_i = 1'b0; aq_ce_i = 1'b0;
    cyc(); cyc();
    chk("pre_rst_ce", 32'(mcb_ce_o), 32'd1);
    chk("pre_rst_state", 32'(tart_state), 32'd2);
    rst_i = 1'b1;
    cyc();
    chk("mid_rst_ce", 32'(mcb_ce_o), 32'd0);
    chk("mid_rst_state", 32'(tart_state), 32'd0);
    rst_i = 1'b0; mcb_rdy_i = 1'b1; aq_ce_i = 1'b1;
    cyc();
    for (int i = 0; i < 2; i++) begin
      aq_valid_i = 1'b1;
      aq_data_i = 24'hD1 + 24'(i);
      expect_wr(i, 24'hD1 + 24'(i));
      cyc();
    end
    aq_valid_i = 1'b0; aq_ce_i = 1'b0;
    wait_done(1'b0, 20);
    chk("post_rst_nxfer", 32'(n_xfer), 32'd2);
    chk("post_rst_qempty", 32'(q_adr.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aq_sdram_scheduler.md
Name: aq_sdram_scheduler

Overview:
Acquisition scheduler that sequences antenna capture into SDRAM through the Memory Controller Block (MCB) command port. Registered antenna samples enter an internal circular FIFO. The FIFO drains one sample per MCB write command into consecutive word addresses. The block runs the arm → capture → drain → done → re-arm cycle, driven by the SPI start and read-complete strobes. It sits between the capture front-end and the MCB, and exports a 3-bit state for debug.

Parameters:
AXNUM, 24, antenna count / sample width (must be ≤ 32)
MSB, AXNUM-1, sample MSB
ABITS, 20, SDRAM address parameter; word address width is ABITS-1
ASB, ABITS-2, word address MSB
BBITS, 9, FIFO depth is 2^BBITS samples
DELAY, 3, simulation-only non-blocking assignment delay

Ports:
clk_i  in  1  bus/scheduler clock; sole clock
rst_i  in  1  synchronous active-high reset
aq_ce_i  in  1  acquisition enable (level)
aq_valid_i  in  1  sample strobe, one sample per high cycle
aq_data_i  in  AXNUM  antenna sample
rd_req_i  in  1  host read-back complete (pulse), re-arms the block
mcb_ce_o  out  1  MCB command request
mcb_wr_o  out  1  write command flag
mcb_rdy_i  in  1  MCB accepts command this cycle
mcb_adr_o  out  ABITS-1  word address
mcb_dat_o  out  32  write data
overflow_o  out  1  sticky sample-dropped flag
tart_state  out  3  state encoding

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high. All state is sampled on posedge clk_i; all outputs are registered.
- Reset values (all outputs, plus internals):
  - mcb_ce_o=0, mcb_wr_o=0, mcb_adr_o=0, mcb_dat_o=0, overflow_o=0, tart_state=IDLE.
  - FIFO pointers, FIFO count and sample counter cleared.
  - Reset asserted mid-operation aborts any pending command immediately; FIFO contents are discarded.
- States (tart_state encoding): IDLE=0, CAPTURE=1, DRAIN=2, DONE=3. Codes 4–7 are unused; if reached, next state is IDLE.
- IDLE:
  - aq_ce_i=1 → CAPTURE.
  - On entry to CAPTURE: sample counter, address and overflow_o are cleared.
- CAPTURE:
  - Samples with aq_valid_i=1 are pushed to the FIFO.
  - The sample counter increments per accepted sample.
  - After sample number 2^(ABITS-1) is accepted → DRAIN.
  - aq_ce_i=0 → DRAIN (early stop); no further samples are accepted.
- DRAIN: aq_valid_i is ignored. When the FIFO is empty and no command is pending → DONE.
- DONE: rd_req_i=1 → IDLE. aq_ce_i is ignored while in DONE.
- FIFO push rule:
  - A push is accepted if count < 2^BBITS, or if a pop occurs in the same cycle.
  - A valid sample in CAPTURE that is not accepted is dropped and sets overflow_o.
  - overflow_o stays set until the next IDLE→CAPTURE transition.
- Simultaneous push and pop: count is unchanged; both pointers advance and wrap modulo 2^BBITS.
- MCB handshake:
  - A command transfers on any cycle with mcb_ce_o=1 and mcb_rdy_i=1.
  - While mcb_ce_o=1 and mcb_rdy_i=0, mcb_adr_o, mcb_dat_o and mcb_wr_o hold stable.
  - After a transfer, if the FIFO is non-empty, the next command is presented on the following cycle (back-to-back, no bubble); otherwise mcb_ce_o drops.
  - mcb_wr_o = mcb_ce_o (write-only block).
- Data format: mcb_dat_o = {(32-AXNUM) zeros, sample}.
- Addressing:
  - The first word of a capture goes to address 0; the address increments by 1 after each transfer.
  - The address wraps to 0 after all-ones. Wrap is only reachable through rd_req_i / re-arm, since a capture stops at 2^(ABITS-1) words.
- Latency:
  - With the FIFO empty and no command pending, a sample accepted at edge k gives mcb_ce_o=1 with that data after edge k+1.
  - Sustained throughput is 1 word/cycle when mcb_rdy_i is held high.
- Early stop with FIFO empty and no pending command: CAPTURE→DRAIN→DONE in consecutive cycles.
- rd_req_i in any state other than DONE is ignored.

Test Plan:
1. Reset/idle: assert rst_i 2 cycles, drive aq_valid_i=1 with aq_ce_i=0 → all outputs 0, tart_state=0, no mcb_ce_o.
2. Full capture, ABITS=6, mcb_rdy_i=1: aq_ce_i=1, samples 0x000001..0x000020 on consecutive cycles → 32 transfers at addresses 0..31 with data 0x00000001..0x00000020, tart_state reaches 3, overflow_o=0.
3. Backpressure, BBITS=2: mcb_rdy_i=0 for 10 cycles while 6 samples arrive → first 4 accepted, overflow_o=1, mcb_adr_o/mcb_dat_o stable at 0/first sample; release → exactly 4 transfers.
4. Full FIFO with pop: count=4, mcb_rdy_i=1 and aq_valid_i=1 on the same cycle → sample accepted, no overflow, count stays 4.
5. Early stop: drop aq_ce_i after 5 samples with mcb_rdy_i toggling 1/0 → 5 transfers (addresses 0..4), then DONE; rd_req_i → IDLE; re-arm → first address 0, overflow_o cleared.
6. Reset mid-drain: rst_i with mcb_ce_o=1 → next cycle mcb_ce_o=0 and tart_state=0; subsequent capture starts at address 0 with no stale data transferred.
